rowbuf_window: RTL and testbench
================================

ROWBUF_WINDOW -- requirements
Module: rowbuf_window

Interface
REQ-001 Parameter COLS, default 28, pixels per image row (line-delay length).
REQ-002 Parameter IMG_ROWS, default 28, rows per frame.
REQ-003 Parameter TAPS, default 5, number of vertical taps; the square window is TAPS x TAPS; TAPS >= 2.
REQ-004 Parameter BIT_WIDTH, default 8, pixel width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_data is accepted this cycle.
REQ-008 in_data  input  BIT_WIDTH  raster-order pixel.
REQ-009 out_taps  output  TAPS*BIT_WIDTH  slice r (r*BIT_WIDTH upward) holds the pixel from the same column, r rows earlier; slice 0 holds the newest pixel.
REQ-010 out_valid  output  1  out_taps, col_idx, row_idx and win_valid are valid this cycle.
REQ-011 col_idx  output  $clog2(COLS)  column of the slice-0 pixel.
REQ-012 row_idx  output  $clog2(IMG_ROWS)  row of the slice-0 pixel.
REQ-013 win_valid  output  1  out_valid and row_idx >= TAPS-1 and col_idx >= TAPS-1.
REQ-014 frame_done  output  1  out_valid for pixel (IMG_ROWS-1, COLS-1).

Function
REQ-015 Each accepted pixel is emitted exactly once, with a latency of 1 cycle: out_valid is asserted in the cycle after in_valid is high and is low otherwise.
REQ-016 Line delays advance only on accepted pixels; cycles with in_valid low leave all storage and counters unchanged.
REQ-017 Slice r equals the pixel accepted exactly r*COLS accepts earlier; slices with r > row_idx are don't-care.
REQ-018 The column counter wraps from COLS-1 to 0 and then increments the row counter; the row counter wraps from IMG_ROWS-1 to 0 (frame boundary) with no idle cycle required.
REQ-019 After a frame wrap, win_valid is not asserted until row_idx >= TAPS-1 in the new frame; rows from the old frame are never flagged as part of a valid window.
REQ-020 win_valid and frame_done are single-cycle qualifiers, and both are low whenever out_valid is low.

Reset
REQ-021 rst high clears the counters, out_valid, win_valid, frame_done, col_idx and row_idx to 0 and out_taps to 0 on the next edge; line-delay storage is not cleared.
REQ-022 rst overrides in_valid in the same cycle: the pixel is dropped. After a mid-frame reset, the next accepted pixel is (0,0).

Configuration
REQ-023 Macro ROWBUF_WINDOW_FLUSH_EN defined: input port flush (1 bit) is added. flush clears the counters and the output qualifiers exactly as rst does, leaves out_taps holding its last value, and takes priority over a simultaneous in_valid.
REQ-024 Macro not defined: no flush port, and the behaviour is otherwise identical.

Structure
REQ-025 Package rowbuf_pkg holds the default COLS/IMG_ROWS/TAPS/BIT_WIDTH constants and a tap-slice index helper function.
REQ-026 Sub-module line_delay: a COLS-deep, BIT_WIDTH-wide enable-gated delay line, instantiated TAPS-1 times in a chain via generate.

Verification (COLS=4, IMG_ROWS=4, TAPS=3, BIT_WIDTH=8)
REQ-027 Stream pixels 0..15 with in_valid held high -> first win_valid on the output of pixel 10 with taps {10,6,2}; 4 win_valid pulses in total (pixels 10, 11, 14, 15); frame_done on pixel 15.
REQ-028 Same stream with in_valid toggling 1,0 -> identical out_taps/index sequence; out_valid only in cycles after an accept.
REQ-029 Reset asserted after pixel 6, then stream 0..15 -> the response matches REQ-027 exactly.
REQ-030 Two back-to-back frames (0..15, 16..31) -> indices restart at (0,0) on pixel 16; the first second-frame win_valid is on pixel 26 with taps {26,22,18}.
REQ-031 With ROWBUF_WINDOW_FLUSH_EN defined, flush asserted together with in_valid at pixel 9 -> pixel dropped, out_valid low next cycle, and the next pixel is reported as (0,0).

Source files
------------

// File: rtl/rowbuf_pkg.sv
// rtl/rowbuf_pkg.sv - default geometry constants and tap-slice helper for rowbuf_window
package rowbuf_pkg;

    localparam int DEF_COLS      = 28;
    localparam int DEF_IMG_ROWS  = 28;
    localparam int DEF_TAPS      = 5;
    localparam int DEF_BIT_WIDTH = 8;

    // LSB position of tap slice r inside the packed out_taps vector
    function automatic int tap_lsb(input int r, input int bw);
        return r * bw;
    endfunction

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - COLS-deep enable-gated delay line; dout_o is the sample pushed COLS enables ago
module line_delay #(
    parameter int COLS      = 28,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 en_i,
    input  logic [BIT_WIDTH-1:0] din_i,
    output logic [BIT_WIDTH-1:0] dout_o
);

    logic [BIT_WIDTH-1:0] mem_q [COLS];

    // Storage is deliberately left out of reset so a reset never costs a row of history
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < COLS; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[COLS-1];

endmodule

// File: rtl/rowbuf_window.sv
// rtl/rowbuf_window.sv - raster line buffer producing a TAPS-high column of pixels with position qualifiers
// Optional flush input enabled by defining ROWBUF_WINDOW_FLUSH_EN.
module rowbuf_window
    import rowbuf_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int IMG_ROWS  = DEF_IMG_ROWS,
    parameter int TAPS      = DEF_TAPS,
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef ROWBUF_WINDOW_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          in_valid,
    input  logic [BIT_WIDTH-1:0]          in_data,
    output logic [TAPS*BIT_WIDTH-1:0]     out_taps,
    output logic                          out_valid,
    output logic [$clog2(COLS)-1:0]       col_idx,
    output logic [$clog2(IMG_ROWS)-1:0]   row_idx,
    output logic                          win_valid,
    output logic                          frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(IMG_ROWS);

    logic flush_w;
`ifdef ROWBUF_WINDOW_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic accept_w;
    assign accept_w = in_valid & ~rst & ~flush_w;

    logic [TAPS*BIT_WIDTH-1:0] taps_w;

    // Slice 0 is the incoming pixel; each further slice is the previous one delayed by a full row
    for (genvar r = 0; r < TAPS; r++) begin : g_tap
        if (r == 0) begin : g_head
            assign taps_w[tap_lsb(0, BIT_WIDTH) +: BIT_WIDTH] = in_data;
        end else begin : g_delay
            line_delay #(
                .COLS      (COLS),
                .BIT_WIDTH (BIT_WIDTH)
            ) u_line_delay (
                .clk    (clk),
                .en_i   (accept_w),
                .din_i  (taps_w[tap_lsb(r-1, BIT_WIDTH) +: BIT_WIDTH]),
                .dout_o (taps_w[tap_lsb(r, BIT_WIDTH) +: BIT_WIDTH])
            );
        end
    end

    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_idx_q, col_idx_d;
    logic [RW-1:0]             row_idx_q, row_idx_d;
    logic [TAPS*BIT_WIDTH-1:0] out_taps_q, out_taps_d;
    logic                      out_valid_q, out_valid_d;
    logic                      win_valid_q, win_valid_d;
    logic                      frame_done_q, frame_done_d;

    logic last_col_w, last_row_w;
    assign last_col_w = (col_q == CW'(COLS-1));
    assign last_row_w = (row_q == RW'(IMG_ROWS-1));

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        out_taps_d   = out_taps_q;
        out_valid_d  = 1'b0;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (flush_w) begin
            col_d     = '0;
            row_d     = '0;
            col_idx_d = '0;
            row_idx_d = '0;
        end else if (in_valid) begin
            out_valid_d  = 1'b1;
            out_taps_d   = taps_w;
            col_idx_d    = col_q;
            row_idx_d    = row_q;
            // Row counter restarts each frame, so old-frame rows can never qualify a window
            win_valid_d  = (int'(col_q) >= TAPS-1) && (int'(row_q) >= TAPS-1);
            frame_done_d = last_col_w && last_row_w;
            if (last_col_w) begin
                col_d = '0;
                row_d = last_row_w ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            out_taps_q   <= '0;
            out_valid_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            out_taps_q   <= out_taps_d;
            out_valid_q  <= out_valid_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_taps   = out_taps_q;
    assign out_valid  = out_valid_q;
    assign col_idx    = col_idx_q;
    assign row_idx    = row_idx_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rowbuf_window.sv
// tb/tb_rowbuf_window.sv - scoreboard bench for rowbuf_window with a history-based reference model
module tb_rowbuf_window;

    localparam int COLS     = 4;
    localparam int IMG_ROWS = 4;
    localparam int TAPS     = 3;
    localparam int BW       = 8;
    localparam int CW       = $clog2(COLS);
    localparam int RW       = $clog2(IMG_ROWS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [BW-1:0]        in_data = '0;
`ifdef ROWBUF_WINDOW_FLUSH_EN
    logic                 flush = 1'b0;
`endif
    logic [TAPS*BW-1:0]   out_taps;
    logic                 out_valid;
    logic [CW-1:0]        col_idx;
    logic [RW-1:0]        row_idx;
    logic                 win_valid;
    logic                 frame_done;

    always #5 clk = ~clk;

    rowbuf_window #(
        .COLS      (COLS),
        .IMG_ROWS  (IMG_ROWS),
        .TAPS      (TAPS),
        .BIT_WIDTH (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ROWBUF_WINDOW_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_taps   (out_taps),
        .out_valid  (out_valid),
        .col_idx    (col_idx),
        .row_idx    (row_idx),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [TAPS*BW-1:0] taps;
        int                 row;
        int                 col;
        bit                 win;
        bit                 fd;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   k = 0;
    int   checks = 0;
    int   errors = 0;
    int   win_cnt = 0;
    int   fd_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: position is the accept count since reset, slice r is the pixel r*COLS accepts back
    function automatic void model_accept(input int d);
        exp_t e;
        int   n;
        hist.push_back(d & 255);
        n      = hist.size() - 1;
        e.col  = k % COLS;
        e.row  = (k / COLS) % IMG_ROWS;
        e.taps = '0;
        for (int r = 0; r < TAPS; r++)
            if (r <= e.row) e.taps[r*BW +: BW] = BW'(hist[n - r*COLS]);
        e.win = (e.row >= TAPS-1) && (e.col >= TAPS-1);
        e.fd  = (e.row == IMG_ROWS-1) && (e.col == COLS-1);
        k++;
        sb.push_back(e);
    endfunction

    task automatic cycle(input bit v, input int d, input bit r, input bit f);
        rst      = r;
        in_valid = v;
        in_data  = BW'(d);
`ifdef ROWBUF_WINDOW_FLUSH_EN
        flush    = f;
`endif
        @(posedge clk);
        #1;
        if (r || f) k = 0;
        else if (v) model_accept(d);
        rst      = 1'b0;
        in_valid = 1'b0;
`ifdef ROWBUF_WINDOW_FLUSH_EN
        flush    = 1'b0;
`endif
    endtask

    task automatic reset_state_check();
        check("rst_out_taps",   32'(out_taps),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_col_idx",    32'(col_idx),    32'd0);
        check("rst_row_idx",    32'(row_idx),    32'd0);
        check("rst_win_valid",  32'(win_valid),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    task automatic stream(input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            cycle(1'b1, i, 1'b0, 1'b0);
            if (toggle) cycle(1'b0, 0, 1'b0, 1'b0);
        end
        cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: every output beat must match the oldest pending expectation
    initial begin
        exp_t               e;
        logic [TAPS*BW-1:0] mask;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
                if (out_valid && sb.size() != 0) begin
                    e    = sb.pop_front();
                    mask = '0;
                    for (int r = 0; r < TAPS; r++)
                        if (r <= e.row) mask[r*BW +: BW] = '1;
                    check("out_taps",   32'(out_taps & mask), 32'(e.taps));
                    check("col_idx",    32'(col_idx),         32'(e.col));
                    check("row_idx",    32'(row_idx),         32'(e.row));
                    check("win_valid",  32'(win_valid),       32'(e.win));
                    check("frame_done", 32'(frame_done),      32'(e.fd));
                    if (win_valid) win_cnt++;
                    if (frame_done) fd_cnt++;
                end else if (!out_valid) begin
                    check("idle_win_valid",  32'(win_valid),  32'd0);
                    check("idle_frame_done", 32'(frame_done), 32'd0);
                    sb.delete();
                end
            end
        end
    end

    initial begin
        cycle(1'b1, 99, 1'b1, 1'b0);
        cycle(1'b1, 98, 1'b1, 1'b0);
        mon_en = 1'b1;
        reset_state_check();

        win_cnt = 0; fd_cnt = 0;
        stream(0, 15, 1'b0);
        check("frame_win_count", 32'(win_cnt), 32'd4);
        check("frame_fd_count",  32'(fd_cnt),  32'd1);

        win_cnt = 0; fd_cnt = 0;
        stream(0, 15, 1'b1);
        check("toggle_win_count", 32'(win_cnt), 32'd4);
        check("toggle_fd_count",  32'(fd_cnt),  32'd1);

        stream(0, 6, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b0);
        reset_state_check();
        win_cnt = 0; fd_cnt = 0;
        stream(0, 15, 1'b0);
        check("midrst_win_count", 32'(win_cnt), 32'd4);
        check("midrst_fd_count",  32'(fd_cnt),  32'd1);

        win_cnt = 0; fd_cnt = 0;
        stream(0, 31, 1'b0);
        check("twoframe_win_count", 32'(win_cnt), 32'd8);
        check("twoframe_fd_count",  32'(fd_cnt),  32'd2);

`ifdef ROWBUF_WINDOW_FLUSH_EN
        cycle(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i <= 8; i++) cycle(1'b1, i, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_taps_hold", 32'(out_taps),  32'h000408);
        cycle(1'b1, 10, 1'b0, 1'b0);
        check("post_flush_col", 32'(col_idx), 32'd0);
        check("post_flush_row", 32'(row_idx), 32'd0);
        cycle(1'b0, 0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            bit f;
            f = 1'b0;
`ifdef ROWBUF_WINDOW_FLUSH_EN
            f = ($urandom_range(0, 39) == 0);
`endif
            cycle(($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 49) == 0), f);
        end
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
